// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types plus the arbiter's FSM state and grant-class encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_DATA  = 1'b0,
        ARB_INSTR = 1'b1
    } arb_cls_t;

    // A single core still needs a one-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational find-first-set starting at ptr, wrapping past N-1 back to 0.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest pending requester wins.
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = N - 1; off >= 0; off--) begin
            cand  = (int'(ptr) + off >= N) ? (int'(ptr) + off - N) : (int'(ptr) + off);
            valid = valid | req[cand];
            idx   = req[cand] ? PW'(cand) : idx;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Registered-grant arbiter sharing one RAM port between the I- and D-caches
// of CPUS cores: data beats instruction, round-robin within each class.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  word_t [CPUS-1:0]    daddr,
    input  word_t [CPUS-1:0]    dstore,
    input  logic [CPUS-1:0]     iREN,
    input  word_t [CPUS-1:0]    iaddr,
    output logic [CPUS-1:0]     dwait,
    output logic [CPUS-1:0]     iwait,
    output word_t [CPUS-1:0]    dload,
    output word_t [CPUS-1:0]    iload,
    output logic                ramREN,
    output logic                ramWEN,
    output word_t               ramaddr,
    output word_t               ramstore,
    input  word_t               ramload,
    input  ramstate_t           ramstate
);

    localparam int PW = ptr_width(CPUS);

    arb_state_t        state_q, state_d;
    arb_cls_t          gcls_q, gcls_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [PW-1:0]     dptr_q, dptr_d;
    logic [PW-1:0]     iptr_q, iptr_d;

    logic [CPUS-1:0]   dpend_s;
    logic              dvalid_s, ivalid_s;
    logic [PW-1:0]     didx_s, iidx_s;
    logic [PW-1:0]     gnext_s;

    assign dpend_s = dREN | dWEN;
    assign gnext_s = (gidx_q == PW'(CPUS - 1)) ? '0 : gidx_q + PW'(1);
    assign dload   = {CPUS{ramload}};
    assign iload   = {CPUS{ramload}};

    rr_picker #(.N(CPUS), .PW(PW)) u_dpick (
        .req   (dpend_s),
        .ptr   (dptr_q),
        .valid (dvalid_s),
        .idx   (didx_s)
    );

    rr_picker #(.N(CPUS), .PW(PW)) u_ipick (
        .req   (iREN),
        .ptr   (iptr_q),
        .valid (ivalid_s),
        .idx   (iidx_s)
    );

    // Next-state, pointer update and live RAM-port muxing for the current grant.
    always_comb begin
        state_d  = state_q;
        gcls_d   = gcls_q;
        gidx_d   = gidx_q;
        dptr_d   = dptr_q;
        iptr_d   = iptr_q;
        dwait    = '1;
        iwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IDLE: begin
                if (dvalid_s) begin
                    gcls_d  = ARB_DATA;
                    gidx_d  = didx_s;
                    state_d = GRANT;
                end else if (ivalid_s) begin
                    gcls_d  = ARB_INSTR;
                    gidx_d  = iidx_s;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (gcls_q == ARB_DATA) begin
                    // A withdrawn request abandons the grant with no acknowledge.
                    if (dpend_s[gidx_q]) begin
                        ramaddr  = daddr[gidx_q];
                        ramstore = dstore[gidx_q];
                        ramWEN   = dWEN[gidx_q];
                        ramREN   = dREN[gidx_q] & ~dWEN[gidx_q];
                        if (ramstate == ACCESS) begin
                            dwait[gidx_q] = 1'b0;
                            dptr_d        = gnext_s;
                            state_d       = IDLE;
                        end else begin
                            state_d = GRANT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (iREN[gidx_q]) begin
                        ramaddr = iaddr[gidx_q];
                        ramREN  = 1'b1;
                        if (ramstate == ACCESS) begin
                            iwait[gidx_q] = 1'b0;
                            iptr_d        = gnext_s;
                            state_d       = IDLE;
                        end else begin
                            state_d = GRANT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and pointer registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            gcls_q  <= ARB_DATA;
            gidx_q  <= '0;
            dptr_q  <= '0;
            iptr_q  <= '0;
        end else begin
            state_q <= state_d;
            gcls_q  <= gcls_d;
            gidx_q  <= gidx_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench: requests predict their completion order into a queue,
// a negedge monitor pops and compares each acknowledge.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int C = 2;

    logic                CLK;
    logic                nRST;
    logic [C-1:0]        dREN, dWEN, iREN;
    logic [C-1:0][31:0]  daddr, dstore, iaddr;
    logic [C-1:0]        dwait, iwait;
    logic [C-1:0][31:0]  dload, iload;
    logic                ramREN, ramWEN;
    logic [31:0]         ramaddr, ramstore, ramload;
    ramstate_t           ramstate;

    ram_arbiter #(.CPUS(C)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iREN(iREN), .iaddr(iaddr),
        .dwait(dwait), .iwait(iwait), .dload(dload), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          cls;
        int          idx;
        logic [31:0] addr;
        logic        wen;
        logic        ren;
        logic [31:0] store;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_dptr = 0;
    int   m_iptr = 0;
    int   d_cnt[C];
    int   i_cnt[C];
    int   d_seen[C];
    int   i_seen[C];
    int   outstanding = 0;
    bit   ram_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every acknowledge must be the next predicted transaction.
    always @(negedge CLK) begin : mon
        int   lows;
        int   wcls;
        int   widx;
        exp_t e;
        lows = 0;
        wcls = 0;
        widx = 0;
        if (nRST) begin
            for (int k = 0; k < C; k++) begin
                if (!dwait[k]) begin lows++; wcls = 0; widx = k; d_cnt[k]++; end
                if (!iwait[k]) begin lows++; wcls = 1; widx = k; i_cnt[k]++; end
            end
            if (lows != 0) begin
                chk("ack_count", lows, 1);
                chk("ack_on_access", ramstate, ACCESS);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", wcls * 16 + widx, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_who", wcls * 16 + widx, e.cls * 16 + e.idx);
                    chk("ack_addr", ramaddr, e.addr);
                    chk("ack_wen", ramWEN, e.wen);
                    chk("ack_ren", ramREN, e.ren);
                    chk("ack_store", ramstore, e.store);
                    chk("ack_load", (wcls == 1) ? iload[widx] : dload[widx], ramload);
                end
            end
        end
    end

    task automatic rand_ram();
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0, 1: ramstate = ACCESS;
            2:    ramstate = FREE;
            3:    ramstate = BUSY;
            default: ramstate = ERROR;
        endcase
        ramload = $urandom;
    endtask

    // Advance one cycle; requesters drop their request after being acknowledged.
    task automatic tick();
        @(posedge CLK);
        #1;
        for (int k = 0; k < C; k++) begin
            if (d_cnt[k] != d_seen[k]) begin
                d_seen[k] = d_cnt[k];
                dREN[k] = 1'b0;
                dWEN[k] = 1'b0;
                outstanding--;
            end
            if (i_cnt[k] != i_seen[k]) begin
                i_seen[k] = i_cnt[k];
                iREN[k] = 1'b0;
                outstanding--;
            end
        end
        if (ram_rand) rand_ram();
    endtask

    // Reference: requests held until served are completed greedily, data class first,
    // each class scanning round-robin from its pointer.
    task automatic raise(input logic [C-1:0] rm, input logic [C-1:0] wm, input logic [C-1:0] im);
        bit   dp[C];
        bit   ip[C];
        bit   any_d;
        bit   any_i;
        exp_t e;
        for (int k = 0; k < C; k++) begin
            dp[k] = rm[k] | wm[k];
            ip[k] = im[k];
        end
        forever begin
            any_d = 1'b0;
            any_i = 1'b0;
            for (int k = 0; k < C; k++) begin
                any_d |= dp[k];
                any_i |= ip[k];
            end
            if (!any_d && !any_i) break;
            for (int off = 0; off < C; off++) begin
                int k;
                k = any_d ? (m_dptr + off) % C : (m_iptr + off) % C;
                if (any_d ? dp[k] : ip[k]) begin
                    e.cls = any_d ? 0 : 1;
                    e.idx = k;
                    e.addr  = any_d ? daddr[k] : iaddr[k];
                    e.wen   = any_d ? wm[k] : 1'b0;
                    e.ren   = any_d ? (rm[k] & ~wm[k]) : 1'b1;
                    e.store = any_d ? dstore[k] : 32'h0;
                    exp_q.push_back(e);
                    outstanding++;
                    if (any_d) begin dp[k] = 1'b0; m_dptr = (k + 1) % C; end
                    else       begin ip[k] = 1'b0; m_iptr = (k + 1) % C; end
                    break;
                end
            end
        end
        dREN = rm;
        dWEN = wm;
        iREN = im;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (outstanding > 0 && t < 500) begin
            tick();
            t++;
        end
        if (outstanding != 0) begin
            chk("round_timeout", outstanding, 0);
            nRST = 1'b0;
            dREN = '0; dWEN = '0; iREN = '0;
            tick();
            tick();
            exp_q.delete();
            outstanding = 0;
            m_dptr = 0;
            m_iptr = 0;
            nRST = 1'b1;
        end
    endtask

    task automatic rand_addrs();
        for (int k = 0; k < C; k++) begin
            daddr[k]  = $urandom;
            dstore[k] = $urandom;
            iaddr[k]  = $urandom;
        end
    endtask

    initial begin
        for (int k = 0; k < C; k++) begin
            d_cnt[k] = 0; i_cnt[k] = 0; d_seen[k] = 0; i_seen[k] = 0;
        end
        nRST = 1'b0;
        dREN = '0; dWEN = '0; iREN = '0;
        daddr = '0; dstore = '0; iaddr = '0;
        ramload = 32'h0;
        ramstate = FREE;
        tick();
        tick();
        @(negedge CLK);
        chk("rst_dwait", dwait, 2'b11);
        chk("rst_iwait", iwait, 2'b11);
        chk("rst_strobes", {ramREN, ramWEN}, 2'b00);
        chk("rst_addr", ramaddr, 32'h0);
        chk("rst_store", ramstore, 32'h0);
        tick();
        nRST = 1'b1;

        // Single read: ACCESS on the third grant cycle.
        rand_addrs();
        daddr[0] = 32'h100;
        ramstate = BUSY;
        raise(2'b01, 2'b00, 2'b00);
        for (int c = 1; c <= 2; c++) begin
            tick();
            ramstate = BUSY;
            @(negedge CLK);
            chk("lat_ren", ramREN, 1'b1);
            chk("lat_addr", ramaddr, 32'h100);
            chk("lat_wait_hi", dwait, 2'b11);
        end
        tick();
        ramstate = ACCESS;
        ramload  = 32'hCAFE0001;
        @(negedge CLK);
        chk("lat_wait_lo", dwait, 2'b10);
        chk("lat_dload", dload[0], 32'hCAFE0001);
        tick();
        ramstate = FREE;
        @(negedge CLK);
        chk("idle_ren", ramREN, 1'b0);
        chk("idle_outstanding", outstanding, 0);

        ram_rand = 1'b1;
        rand_addrs();
        raise(2'b00, 2'b10, 2'b01);
        wait_done();
        rand_addrs();
        raise(2'b11, 2'b00, 2'b00);
        wait_done();
        rand_addrs();
        raise(2'b11, 2'b00, 2'b00);
        wait_done();
        rand_addrs();
        raise(2'b01, 2'b01, 2'b00);
        wait_done();

        // ERROR is never an acknowledge.
        ram_rand = 1'b0;
        rand_addrs();
        ramstate = ERROR;
        raise(2'b10, 2'b00, 2'b00);
        for (int c = 1; c <= 5; c++) begin
            tick();
            ramstate = ERROR;
            @(negedge CLK);
            chk("err_wait", dwait, 2'b11);
            chk("err_ren", ramREN, 1'b1);
        end
        tick();
        ramstate = ACCESS;
        tick();
        ramstate = FREE;
        chk("err_done", outstanding, 0);

        // Withdraw a granted instruction request; iptr must not move.
        ram_rand = 1'b1;
        rand_addrs();
        raise(2'b00, 2'b00, 2'b01);
        wait_done();
        ram_rand = 1'b0;
        ramstate = BUSY;
        iREN[1] = 1'b1;
        tick();
        ramstate = BUSY;
        @(negedge CLK);
        chk("wd_ren", ramREN, 1'b1);
        chk("wd_addr", ramaddr, iaddr[1]);
        tick();
        iREN[1] = 1'b0;
        ramstate = ACCESS;
        @(negedge CLK);
        chk("wd_drop", {ramREN, ramWEN}, 2'b00);
        chk("wd_iwait", iwait, 2'b11);
        tick();
        ramstate = FREE;
        ram_rand = 1'b1;
        rand_addrs();
        raise(2'b00, 2'b00, 2'b11);
        wait_done();

        // Reset in the middle of a grant.
        rand_addrs();
        raise(2'b01, 2'b00, 2'b00);
        wait_done();
        ram_rand = 1'b0;
        ramstate = BUSY;
        dREN[1] = 1'b1;
        tick();
        nRST = 1'b0;
        @(negedge CLK);
        chk("mr_ren_before", ramREN, 1'b1);
        tick();
        @(negedge CLK);
        chk("mr_strobes", {ramREN, ramWEN}, 2'b00);
        chk("mr_dwait", dwait, 2'b11);
        chk("mr_iwait", iwait, 2'b11);
        dREN = '0;
        m_dptr = 0;
        m_iptr = 0;
        tick();
        nRST = 1'b1;
        ram_rand = 1'b1;
        rand_addrs();
        raise(2'b11, 2'b00, 2'b00);
        wait_done();

        for (int r = 0; r < 40; r++) begin
            logic [C-1:0] rm, wm, im;
            rand_addrs();
            rm = C'($urandom);
            wm = C'($urandom);
            im = C'($urandom);
            raise(rm, wm, im);
            wait_done();
        end

        tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
